// File: rtl/interp_pkg.sv
// Shared state encodings and block geometry for the luma block interpolation sequencer.
package interp_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_FETCH = 3'd1;
   localparam logic [2:0] ST_VERT  = 3'd2;
   localparam logic [2:0] ST_DRAIN = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   localparam int N_ROWS      = 15;
   localparam int N_VERT      = 32;
   localparam int SEL_H_FIRST = 3;
   localparam int SEL_H_LAST  = 10;
   localparam int SEL_V_BASE  = 15;

endpackage

// File: rtl/interp_tag_pipe.sv
// FILT_LAT-deep shift of {vld, sel} that tracks ops through the filter pipeline.
// The last stage doubles as the output-filler strobe/select register.
module interp_tag_pipe
   import interp_pkg::*;
#(
   parameter int FILT_LAT = 4
)(
   input  logic       clock,
   input  logic       reset_L,
   input  logic       i_vld,
   input  logic [7:0] i_sel,
   output logic       o_vld,
   output logic [7:0] o_sel,
   output logic       o_empty_next
);

   logic [FILT_LAT-1:0] r_vld;
   logic [7:0]          r_sel [FILT_LAT];

   // sel only advances with a valid tag so the output select holds between writes
   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         r_vld <= '0;
         for (int i = 0; i < FILT_LAT; i++) r_sel[i] <= '0;
      end else begin
         r_vld[0] <= i_vld;
         if (i_vld) r_sel[0] <= i_sel;
         for (int i = 1; i < FILT_LAT; i++) begin
            r_vld[i] <= r_vld[i-1];
            if (r_vld[i-1]) r_sel[i] <= r_sel[i-1];
         end
      end
   end

   // True when nothing will remain in flight after the output stage drains this cycle
   always_comb begin
      o_empty_next = ~i_vld;
      for (int i = 0; i < FILT_LAT - 1; i++) begin
         if (r_vld[i]) o_empty_next = 1'b0;
      end
   end

   assign o_vld = r_vld[FILT_LAT-1];
   assign o_sel = r_sel[FILT_LAT-1];

endmodule

// File: rtl/interp_block_sequencer.sv
// Sequences one 8x8 luma block: 15 row fetches (horizontal ops), 32 vertical ops,
// drain of the filter pipeline, then a valid/ready handoff downstream.
module interp_block_sequencer
   import interp_pkg::*;
#(
   parameter int ADDR_W    = 16,
   parameter int ROW_PITCH = 64,
   parameter int FILT_LAT  = 4
)(
   input  logic              clock,
   input  logic              reset_L,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_blk_addr,
   output logic              o_busy,
   output logic              o_rd_req,
   output logic [ADDR_W-1:0] o_rd_addr,
   input  logic              i_rd_gnt,
   input  logic              i_rd_valid,
   output logic              o_sr_load_L,
   output logic              o_filt_vld,
   output logic              o_filt_vert,
   output logic [1:0]        o_filt_phase,
   output logic              o_of_load_L,
   output logic [7:0]        o_of_sel,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic              o_err
);

   logic [2:0]        r_state;
   logic [2:0]        w_state_next;
   logic [3:0]        r_issued;
   logic [3:0]        r_returned;
   logic [4:0]        r_v;
   logic [ADDR_W-1:0] r_base;
   logic              r_err;
   logic              w_issue;
   logic              w_row_ld;
   logic              w_empty_next;
   logic [7:0]        w_tag_sel;
   logic              w_tag_out_vld;

   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) r_state <= ST_IDLE;
      else          r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:  if (i_start) w_state_next = ST_FETCH;
         ST_FETCH: if (w_row_ld && r_returned == 4'(N_ROWS - 1)) w_state_next = ST_VERT;
         ST_VERT:  if (r_v == 5'(N_VERT - 1)) w_state_next = ST_DRAIN;
         ST_DRAIN: if (w_empty_next) w_state_next = ST_DONE;
         ST_DONE:  if (i_out_ready) w_state_next = ST_IDLE;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      o_busy       = (r_state != ST_IDLE);
      o_rd_req     = (r_state == ST_FETCH) && (r_issued < 4'(N_ROWS));
      w_row_ld     = (r_state == ST_FETCH) && i_rd_valid && (r_returned < 4'(N_ROWS));
      o_sr_load_L  = ~w_row_ld;
      o_filt_vert  = (r_state == ST_VERT);
      o_filt_vld   = w_row_ld | o_filt_vert;
      o_filt_phase = o_filt_vert ? r_v[4:3] : 2'b00;
      o_out_valid  = (r_state == ST_DONE);
   end

   assign w_issue   = o_rd_req & i_rd_gnt;
   assign o_rd_addr = r_base + ADDR_W'(r_issued) * ADDR_W'(ROW_PITCH);
   assign w_tag_sel = o_filt_vert ? (8'(SEL_V_BASE) + {3'b000, r_v}) : {4'b0000, r_returned};

   // Any read return that is not a legitimate row load is flagged until reset
   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         r_issued   <= '0;
         r_returned <= '0;
         r_v        <= '0;
         r_base     <= '0;
         r_err      <= 1'b0;
      end else begin
         if (r_state == ST_IDLE && i_start) begin
            r_base     <= i_blk_addr;
            r_issued   <= '0;
            r_returned <= '0;
            r_v        <= '0;
         end else begin
            if (w_issue)     r_issued   <= r_issued + 4'd1;
            if (w_row_ld)    r_returned <= r_returned + 4'd1;
            if (o_filt_vert) r_v        <= r_v + 5'd1;
         end
         if (i_rd_valid && !w_row_ld) r_err <= 1'b1;
      end
   end

   assign o_err = r_err;

   interp_tag_pipe #(
      .FILT_LAT (FILT_LAT)
   ) u_tag_pipe (
      .clock        (clock),
      .reset_L      (reset_L),
      .i_vld        (o_filt_vld),
      .i_sel        (w_tag_sel),
      .o_vld        (w_tag_out_vld),
      .o_sel        (o_of_sel),
      .o_empty_next (w_empty_next)
   );

   assign o_of_load_L = ~w_tag_out_vld;

endmodule
